// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALU op codes, op-code width and FSM state encoding.
package alu_pkg;
  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] ALU_AND = 4'd0;
  localparam logic [OP_W-1:0] ALU_OR  = 4'd1;
  localparam logic [OP_W-1:0] ALU_XOR = 4'd2;
  localparam logic [OP_W-1:0] ALU_NOR = 4'd3;
  localparam logic [OP_W-1:0] ALU_ADD = 4'd4;
  localparam logic [OP_W-1:0] ALU_SUB = 4'd5;
  localparam logic [OP_W-1:0] ALU_SLT = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-side bus of the shared-ALU arbiter.
// Per-requester fields are packed [N_REQ-1:0][..], so requester i occupies slice [i*WIDTH +: WIDTH].
interface alu_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
);
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0][WIDTH-1:0] req_x;
  logic [N_REQ-1:0][WIDTH-1:0] req_y;
  logic [N_REQ-1:0][OP_W-1:0]  req_op;
  logic [N_REQ-1:0]            resp_valid;
  logic [N_REQ-1:0]            resp_ready;
  logic [WIDTH-1:0]            resp_data;
  logic [WIDTH-1:0]            alu_x;
  logic [WIDTH-1:0]            alu_y;
  logic [OP_W-1:0]             alu_op;
  logic [WIDTH-1:0]            alu_z;

  modport slave (
    input  req_valid, req_x, req_y, req_op, resp_ready, alu_z,
    output req_ready, resp_valid, resp_data, alu_x, alu_y, alu_op
  );

  modport master (
    output req_valid, req_x, req_y, req_op, resp_ready, alu_z,
    input  req_ready, resp_valid, resp_data, alu_x, alu_y, alu_op
  );
endinterface

// File: rtl/alu_rr_pick.sv
// Combinational grant picker: request vector (+ round-robin pointer) -> one-hot grant and index.
// ALU_ARB_FIXED_PRIO_EN selects fixed lowest-index priority and removes the pointer input.
module alu_rr_pick #(
  parameter int N_REQ = 4,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
`ifndef ALU_ARB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0] i_ptr,
`endif
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);
`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (i_req[IDX_W'(k)] && !o_any) begin
        o_any = 1'b1;
        o_idx = IDX_W'(k);
      end
    end
    if (o_any) o_gnt[o_idx] = 1'b1;
  end
`else
  int               w_j;
  logic [IDX_W-1:0] w_jj;

  // Search starts one past the last served requester, so it ends up with lowest priority.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    w_jj  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= N_REQ) w_j = w_j - N_REQ;
      w_jj = IDX_W'(w_j);
      if (i_req[w_jj] && !o_any) begin
        o_any = 1'b1;
        o_idx = w_jj;
      end
    end
    if (o_any) o_gnt[o_idx] = 1'b1;
  end
`endif
endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between N_REQ requesters: IDLE (grant) -> ISSUE -> RESP.
// Build option ALU_ARB_FIXED_PRIO_EN: fixed priority instead of round-robin.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int OP_W  = alu_pkg::OP_W
) (
  input logic       clk,
  input logic       rst,
  alu_arbiter_if.slave bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [IDX_W-1:0] r_idx;
  logic [N_REQ-1:0] r_resp_valid;
  logic [WIDTH-1:0] r_x, r_y, r_data;
  logic [OP_W-1:0]  r_op;
  logic [N_REQ-1:0] w_gnt;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] r_ptr;
`endif

  alu_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req (bus.req_valid),
`ifndef ALU_ARB_FIXED_PRIO_EN
    .i_ptr (r_ptr),
`endif
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Accept pulse must coincide with the operand latch edge; masked so reset forces it low.
  assign bus.req_ready  = (r_state == ST_IDLE && !rst) ? w_gnt : '0;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_data;
  assign bus.alu_x      = r_x;
  assign bus.alu_y      = r_y;
  assign bus.alu_op     = r_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_gnt        <= '0;
      r_idx        <= '0;
      r_resp_valid <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_op         <= '0;
      r_data       <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      r_ptr        <= IDX_W'(N_REQ - 1);
`endif
    end else begin
      case (r_state)
        ST_IDLE: if (w_any) begin
          r_gnt   <= w_gnt;
          r_idx   <= w_idx;
          r_x     <= bus.req_x[w_idx];
          r_y     <= bus.req_y[w_idx];
          r_op    <= bus.req_op[w_idx];
          r_state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          r_data       <= bus.alu_z;
          r_resp_valid <= r_gnt;
          r_state      <= ST_RESP;
        end
        ST_RESP: if (bus.resp_ready[r_idx]) begin
          r_resp_valid <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
          r_ptr        <= r_idx;
`endif
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
